// File: rtl/data_mem.sv
// data_mem: byte-addressable little-endian data memory behind a fixed-latency
// request/response port with byte/half/word access and misalignment flagging.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | req_ready high, waiting for a request
// WAIT  | request captured, counting down wait states; access at count 0
// RESP  | one-cycle response strobe on rsp_valid, then back to IDLE
module data_mem #(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int         WORDS     = 2 ** (ADDR_W - 2);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic accept;
  logic do_access;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       wdata_q;

  logic              misalign;
  logic [3:0]        be;
  logic [3:0][7:0]   wlane;
  logic [3:0][7:0]   rd_word;
  logic [31:0]       shifted;
  logic [31:0]       load_val;
  logic [ADDR_W-3:0] word_idx;

  // Word-organised storage with byte enables; zero at power-up, never reset.
  logic [3:0][7:0] mem [WORDS] = '{default: '0};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    do_access = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = WAIT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          do_access = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      wdata_q <= req_wdata;
    end
  end

  assign word_idx = addr_q[ADDR_W-1:2];
  assign rd_word  = mem[word_idx];

  always_comb begin
    misalign = 1'b0;
    case (size_q)
      2'd1:    misalign = addr_q[0];
      2'd2:    misalign = (addr_q[1:0] != 2'd0);
      default: misalign = (size_q == 2'd3);
    endcase
  end

  // Replicate store data across lanes so the byte enables pick the right copy.
  always_comb begin
    be    = 4'b0000;
    wlane = wdata_q;
    case (size_q)
      2'd0: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        be    = 4'b0011 << addr_q[1:0];
        wlane = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata_q;
      end
    endcase
  end

  always_comb begin
    shifted  = rd_word >> {addr_q[1:0], 3'b000};
    load_val = rd_word;
    case (size_q)
      2'd0:    load_val = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'd1:    load_val = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: load_val = rd_word;
    endcase
  end

  always_ff @(posedge clock) begin
    if (do_access && we_q && !misalign) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][b] <= wlane[b];
      end
    end
  end

  // Response registers are zero outside the single RESP cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
    end else begin
      rsp_valid <= do_access;
      rsp_err   <= do_access & misalign;
      rsp_rdata <= (do_access && !misalign && !we_q) ? load_val : 32'd0;
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed vector table plus hand-written reset and wait-state
// sequences for data_mem, using one zero-wait and one five-wait instance.
`timescale 1ns/1ps
module tb_data_mem;
  localparam int ADDR_W = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic              reset, req_valid, req_ready, req_we, req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic [31:0]       req_wdata, rsp_rdata;
  logic              rsp_valid, rsp_err;

  logic              reset5, req_valid5, req_ready5, req_we5, req_unsigned5;
  logic [ADDR_W-1:0] req_addr5;
  logic [1:0]        req_size5;
  logic [31:0]       req_wdata5, rsp_rdata5;
  logic              rsp_valid5, rsp_err5;

  data_mem #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) u_dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem #(.ADDR_W(ADDR_W), .WAIT_CYCLES(5)) u_dut5 (
    .clock(clock), .reset(reset5), .req_valid(req_valid5), .req_ready(req_ready5),
    .req_we(req_we5), .req_addr(req_addr5), .req_size(req_size5),
    .req_unsigned(req_unsigned5), .req_wdata(req_wdata5), .rsp_valid(rsp_valid5),
    .rsp_rdata(rsp_rdata5), .rsp_err(rsp_err5)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic              uns;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              err;
  } vec_t;

  vec_t vecs[26];

  // Drives one request on the zero-wait instance and checks the full handshake.
  task automatic do_req(input vec_t v, input int idx, output int acc_cyc);
    int guard;
    int lat;
    bit seen;
    @(negedge clock);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_addr     = v.addr;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_wdata    = v.wdata;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    @(posedge clock);
    #1;
    acc_cyc = cyc;
    // Scramble inputs after accept: the captured request must be used.
    req_valid    = 1'b0;
    req_we       = ~v.we;
    req_addr     = ~v.addr;
    req_size     = v.size ^ 2'b01;
    req_unsigned = ~v.uns;
    req_wdata    = ~v.wdata;
    check($sformatf("v%0d ready low after accept", idx), {63'd0, req_ready}, 64'd0);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
      seen = rsp_valid;
    end
    check($sformatf("v%0d latency", idx), 64'(lat), 64'd1);
    check($sformatf("v%0d rdata", idx), {32'd0, rsp_rdata}, {32'd0, v.rdata});
    check($sformatf("v%0d err", idx), {63'd0, rsp_err}, {63'd0, v.err});
    @(posedge clock);
    #1;
    check($sformatf("v%0d idle outputs", idx), {29'd0, req_ready, rsp_valid, rsp_err, rsp_rdata},
          {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc_cyc, prev_acc, rel_cyc;
    vec_t v;
    bit   flag;
    int   accs, last_acc, low_run, rsp_seen;
    bit   rdy, prev_v;

    vecs[0]  = '{1'b1, 16'h0010, 2'd2, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 16'h0010, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 16'h0011, 2'd0, 1'b0, 32'h00000080, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b0, 16'h0011, 2'd0, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[4]  = '{1'b0, 16'h0011, 2'd0, 1'b1, 32'h0,        32'h00000080, 1'b0};
    vecs[5]  = '{1'b0, 16'h0010, 2'd2, 1'b0, 32'h0,        32'hDEAD80EF, 1'b0};
    vecs[6]  = '{1'b0, 16'h0013, 2'd1, 1'b0, 32'h0,        32'h00000000, 1'b1};
    vecs[7]  = '{1'b1, 16'h0012, 2'd2, 1'b0, 32'h11111111, 32'h00000000, 1'b1};
    vecs[8]  = '{1'b0, 16'h0010, 2'd3, 1'b0, 32'h0,        32'h00000000, 1'b1};
    vecs[9]  = '{1'b1, 16'h0010, 2'd3, 1'b0, 32'h22222222, 32'h00000000, 1'b1};
    vecs[10] = '{1'b0, 16'h0010, 2'd2, 1'b0, 32'h0,        32'hDEAD80EF, 1'b0};
    vecs[11] = '{1'b0, 16'h0012, 2'd1, 1'b0, 32'h0,        32'hFFFFDEAD, 1'b0};
    vecs[12] = '{1'b0, 16'h0010, 2'd1, 1'b1, 32'h0,        32'h000080EF, 1'b0};
    vecs[13] = '{1'b0, 16'h0010, 2'd1, 1'b0, 32'h0,        32'hFFFF80EF, 1'b0};
    vecs[14] = '{1'b1, 16'h0016, 2'd1, 1'b0, 32'h1234ABCD, 32'h00000000, 1'b0};
    vecs[15] = '{1'b0, 16'h0014, 2'd2, 1'b0, 32'h0,        32'hABCD0000, 1'b0};
    vecs[16] = '{1'b1, 16'h0014, 2'd0, 1'b0, 32'hFFFFFF7F, 32'h00000000, 1'b0};
    vecs[17] = '{1'b0, 16'h0014, 2'd2, 1'b0, 32'h0,        32'hABCD007F, 1'b0};
    vecs[18] = '{1'b0, 16'h0017, 2'd0, 1'b0, 32'h0,        32'hFFFFFFAB, 1'b0};
    vecs[19] = '{1'b0, 16'h0016, 2'd0, 1'b1, 32'h0,        32'h000000CD, 1'b0};
    vecs[20] = '{1'b1, 16'hFFFF, 2'd0, 1'b0, 32'h000000A5, 32'h00000000, 1'b0};
    vecs[21] = '{1'b0, 16'hFFFF, 2'd0, 1'b1, 32'h0,        32'h000000A5, 1'b0};
    vecs[22] = '{1'b0, 16'h0000, 2'd0, 1'b1, 32'h0,        32'h00000000, 1'b0};
    vecs[23] = '{1'b0, 16'hFFFC, 2'd2, 1'b0, 32'h0,        32'hA5000000, 1'b0};
    vecs[24] = '{1'b0, 16'h0011, 2'd2, 1'b0, 32'h0,        32'h00000000, 1'b1};
    vecs[25] = '{1'b0, 16'hFFFF, 2'd0, 1'b0, 32'h0,        32'hFFFFFFA5, 1'b0};

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'd0;
    reset5 = 1'b1; req_valid5 = 1'b0; req_we5 = 1'b0; req_addr5 = '0;
    req_size5 = 2'd2; req_unsigned5 = 1'b0; req_wdata5 = 32'd0;

    repeat (3) @(posedge clock);
    #1;
    check("reset outputs", {29'd0, req_ready, rsp_valid, rsp_err, rsp_rdata},
          {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
    check("reset outputs w5", {29'd0, req_ready5, rsp_valid5, rsp_err5, rsp_rdata5},
          {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
    #1;
    reset   = 1'b0;
    reset5  = 1'b0;
    rel_cyc = cyc;

    prev_acc = 0;
    for (int i = 0; i < 26; i++) begin
      do_req(vecs[i], i, acc_cyc);
      if (i == 0) check("first accept after reset", 64'(acc_cyc - rel_cyc), 64'd1);
      else        check($sformatf("v%0d accept spacing", i), 64'(acc_cyc - prev_acc), 64'd3);
      prev_acc = acc_cyc;
    end

    // Reset during WAIT aborts a store.
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0020; req_size = 2'd2;
    req_wdata = 32'h12345678;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    check("abort: in wait", {63'd0, req_ready}, 64'd0);
    reset = 1'b1;
    #1;
    check("abort: ready during reset", {62'd0, req_ready, rsp_valid}, {62'd0, 1'b1, 1'b0});
    @(negedge clock);
    reset = 1'b0;
    flag = 1'b0;
    repeat (4) begin
      @(posedge clock);
      #1;
      if (rsp_valid) flag = 1'b1;
    end
    check("abort: no response", {63'd0, flag}, 64'd0);
    v = '{1'b0, 16'h0020, 2'd2, 1'b0, 32'h0, 32'h00000000, 1'b0};
    do_req(v, 100, acc_cyc);

    // Reset during RESP drops rsp_valid; the store already landed.
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0024; req_size = 2'd2;
    req_wdata = 32'hCAFEF00D;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(posedge clock);
    #1;
    check("resp reset: valid before", {63'd0, rsp_valid}, 64'd1);
    reset = 1'b1;
    #1;
    check("resp reset: valid dropped", {31'd0, rsp_valid, rsp_rdata}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    v = '{1'b0, 16'h0024, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0};
    do_req(v, 101, acc_cyc);

    // Five wait states with req_valid held high.
    @(negedge clock);
    req_valid5 = 1'b1;
    accs = 0; last_acc = -100; low_run = 0; rsp_seen = 0; prev_v = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clock);
      rdy = req_ready5;
      if (rdy) begin
        if (accs > 0) begin
          check($sformatf("w5 ready-low run %0d", accs), 64'(low_run), 64'd7);
          check($sformatf("w5 accept spacing %0d", accs), 64'(i - last_acc), 64'd8);
        end
        last_acc = i;
        accs++;
        low_run = 0;
      end else begin
        low_run++;
      end
      @(posedge clock);
      #1;
      if (rsp_valid5 && !prev_v) begin
        rsp_seen++;
        check($sformatf("w5 rsp edge %0d", rsp_seen), 64'(i - last_acc), 64'd6);
        check($sformatf("w5 rsp data %0d", rsp_seen), {31'd0, rsp_err5, rsp_rdata5}, 64'd0);
      end
      prev_v = rsp_valid5;
    end
    req_valid5 = 1'b0;
    check("w5 accept count", 64'(accs), 64'd4);
    check("w5 response count", 64'(rsp_seen), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
